// File: rtl/gte_mac_accum.sv
// GTE MAC accumulator: sums three signed lane products into 44-bit MAC1..3, then finalizes MAC/IR/FLAG (`GTE_ACC_RAW_OUT_EN adds o_raw0..2).
// Latency: outputs and o_done appear one cycle after the i_last step.
// Backpressure: none; every accepted step is consumed, steps outside an operation are dropped.
module gte_mac_accum #(
  parameter int ACC_W  = 44,
  parameter int PROD_W = 35
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_first,
  input  logic              i_last,
  input  logic              i_sf,
  input  logic              i_lm,
  input  logic [PROD_W-1:0] i_prod0,
  input  logic [PROD_W-1:0] i_prod1,
  input  logic [PROD_W-1:0] i_prod2,
  input  logic [31:0]       i_bias0,
  input  logic [31:0]       i_bias1,
  input  logic [31:0]       i_bias2,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_mac0,
  output logic [31:0]       o_mac1,
  output logic [31:0]       o_mac2,
  output logic [15:0]       o_ir0,
  output logic [15:0]       o_ir1,
  output logic [15:0]       o_ir2,
  output logic [31:0]       o_flag
`ifdef GTE_ACC_RAW_OUT_EN
  ,
  output logic [ACC_W-1:0]  o_raw0,
  output logic [ACC_W-1:0]  o_raw1,
  output logic [ACC_W-1:0]  o_raw2
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FIN} state_t;

  localparam logic signed [ACC_W-1:0] IR_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] IR_NEG = ACC_W'(-32768);

  state_t state_q, state_d;
  logic   step, fin_take;

  logic signed [PROD_W-1:0] prod  [3];
  logic signed [31:0]       bias  [3];
  logic signed [ACC_W-1:0]  acc_q [3];
  logic signed [ACC_W-1:0]  acc_d [3];
  logic signed [ACC_W:0]    base  [3];
  logic signed [ACC_W:0]    sum   [3];
  logic signed [ACC_W-1:0]  sh    [3];
  logic [15:0]              ir_d  [3];
  logic signed [ACC_W-1:0]  ir_lo;
  logic [2:0]               pos_q, neg_q, pos_d, neg_d, ir_sat;
  logic [31:0]              flag_d;

  assign prod[0] = i_prod0;
  assign prod[1] = i_prod1;
  assign prod[2] = i_prod2;
  assign bias[0] = i_bias0;
  assign bias[1] = i_bias1;
  assign bias[2] = i_bias2;

  // A step is taken only inside an operation, or when it opens a new one.
  assign step     = i_valid & (i_first | (state_q == S_ACC));
  assign fin_take = step & i_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (step) state_d = i_last ? S_FIN : S_ACC;
      S_ACC:   if (fin_take) state_d = S_FIN;
      S_FIN:   state_d = step ? (i_last ? S_FIN : S_ACC) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q != S_IDLE);
    o_done = (state_q == S_FIN);
  end

  // Finalize works on the post-step accumulator so results land one cycle after i_last.
  always_comb begin
    ir_lo  = i_lm ? '0 : IR_NEG;
    flag_d = '0;
    for (int n = 0; n < 3; n++) begin
      base[n]   = i_first ? {{(ACC_W-43){bias[n][31]}}, bias[n], 12'b0}
                          : {acc_q[n][ACC_W-1], acc_q[n]};
      sum[n]    = base[n] + {{(ACC_W+1-PROD_W){prod[n][PROD_W-1]}}, prod[n]};
      acc_d[n]  = sum[n][ACC_W-1:0];
      pos_d[n]  = (~i_first & pos_q[n]) | (~sum[n][ACC_W] &  sum[n][ACC_W-1]);
      neg_d[n]  = (~i_first & neg_q[n]) | ( sum[n][ACC_W] & ~sum[n][ACC_W-1]);
      sh[n]     = i_sf ? (acc_d[n] >>> 12) : acc_d[n];
      ir_sat[n] = 1'b1;
      if (sh[n] > IR_MAX) begin
        ir_d[n] = 16'h7fff;
      end else if (sh[n] < ir_lo) begin
        ir_d[n] = ir_lo[15:0];
      end else begin
        ir_d[n]   = sh[n][15:0];
        ir_sat[n] = 1'b0;
      end
      flag_d[30-n] = pos_d[n];
      flag_d[27-n] = neg_d[n];
      flag_d[24-n] = ir_sat[n];
    end
    // IR3 saturation (bit 22) deliberately stays out of the summary bit.
    flag_d[31] = |flag_d[30:23];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < 3; n++) acc_q[n] <= '0;
      pos_q  <= '0;
      neg_q  <= '0;
      o_mac0 <= '0;
      o_mac1 <= '0;
      o_mac2 <= '0;
      o_ir0  <= '0;
      o_ir1  <= '0;
      o_ir2  <= '0;
      o_flag <= '0;
`ifdef GTE_ACC_RAW_OUT_EN
      o_raw0 <= '0;
      o_raw1 <= '0;
      o_raw2 <= '0;
`endif
    end else begin
      if (step) begin
        for (int n = 0; n < 3; n++) acc_q[n] <= acc_d[n];
        pos_q <= pos_d;
        neg_q <= neg_d;
      end
      if (fin_take) begin
        o_mac0 <= sh[0][31:0];
        o_mac1 <= sh[1][31:0];
        o_mac2 <= sh[2][31:0];
        o_ir0  <= ir_d[0];
        o_ir1  <= ir_d[1];
        o_ir2  <= ir_d[2];
        o_flag <= flag_d;
`ifdef GTE_ACC_RAW_OUT_EN
        o_raw0 <= acc_d[0];
        o_raw1 <= acc_d[1];
        o_raw2 <= acc_d[2];
`endif
      end
    end
  end

endmodule
